// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals around the shared UART TX arbiter.
// The master modport is the arbiter itself; slave is the surrounding requesters and transmitter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
) ();
    localparam int GW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_last;
    logic [N_REQ-1:0]    req_ready;
    logic [DW-1:0]       tx_data;
    logic                tx_start;
    logic                tx_ready;
    logic [GW-1:0]       grant_id;
    logic                grant_valid;
    logic                busy;

    modport master (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_start, grant_id, grant_valid, busy
    );

    modport slave (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_start, grant_id, grant_valid, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of one UART transmitter among N_REQ byte sources.
// A grant is held until the owner's last-flagged byte has been fully sent.
module uart_tx_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
) (
    input  logic              clk,
    input  logic              rstn,
    uart_tx_arbiter_if.master bus
);
    localparam int                GW      = $clog2(N_REQ);
    localparam logic [GW-1:0]     LAST_ID = GW'(N_REQ - 1);
    localparam logic [GW-1:0]     ONE_ID  = GW'(1);
    localparam logic [N_REQ-1:0]  ONE_REQ = N_REQ'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t             state_r;
    logic [GW-1:0]      rr_r;
    logic [GW-1:0]      grant_id_r;
    logic               grant_valid_r;
    logic               busy_r;
    logic [N_REQ-1:0]   req_ready_r;
    logic [DW-1:0]      tx_data_r;
    logic               tx_start_r;
    logic               last_r;
    logic [1:0]         wait_cnt_r;
    logic               retried_r;

    logic               pick_found_s;
    logic [GW-1:0]      pick_id_s;
    logic               own_valid_s;
    logic [DW-1:0]      own_data_s;
    logic               own_last_s;

    // Scanning downward lets the lowest offset from ptr overwrite any farther candidate.
    function automatic logic [GW:0] rr_pick(input logic [N_REQ-1:0] valid, input logic [GW-1:0] ptr);
        logic [GW:0]   res;
        logic [GW-1:0] idx;
        res = {(GW+1){1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = GW'((int'(ptr) + k) % N_REQ);
            if (valid[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Next round-robin candidate and the current owner's request lines.
    always_comb begin
        {pick_found_s, pick_id_s} = rr_pick(bus.req_valid, rr_r);
        own_valid_s = bus.req_valid[grant_id_r];
        own_data_s  = bus.req_data[int'(grant_id_r)*DW +: DW];
        own_last_s  = bus.req_last[grant_id_r];
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= IDLE;
            rr_r          <= {GW{1'b0}};
            grant_id_r    <= {GW{1'b0}};
            grant_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            req_ready_r   <= {N_REQ{1'b0}};
            tx_data_r     <= {DW{1'b0}};
            tx_start_r    <= 1'b0;
            last_r        <= 1'b0;
            wait_cnt_r    <= 2'd0;
            retried_r     <= 1'b0;
        end else begin
            req_ready_r <= {N_REQ{1'b0}};
            tx_start_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        grant_id_r    <= pick_id_s;
                        grant_valid_r <= 1'b1;
                        busy_r        <= 1'b1;
                        state_r       <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    // The grant is kept even while the owner stalls between bytes.
                    if (own_valid_s && bus.tx_ready) begin
                        tx_data_r   <= own_data_s;
                        req_ready_r <= ONE_REQ << grant_id_r;
                        last_r      <= own_last_s;
                        tx_start_r  <= 1'b1;
                        state_r     <= START;
                    end else begin
                        state_r <= LOAD;
                    end
                end
                START: begin
                    wait_cnt_r <= 2'd0;
                    retried_r  <= 1'b0;
                    state_r    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Ready high through START plus three cycles means the pulse was missed: retry once.
                    if (!bus.tx_ready) begin
                        state_r <= WAIT_DONE;
                    end else if (!retried_r && (wait_cnt_r == 2'd2)) begin
                        tx_start_r <= 1'b1;
                        retried_r  <= 1'b1;
                    end else if (!retried_r) begin
                        wait_cnt_r <= wait_cnt_r + 2'd1;
                    end else begin
                        state_r <= WAIT_BUSY;
                    end
                end
                WAIT_DONE: begin
                    if (bus.tx_ready && last_r) begin
                        grant_valid_r <= 1'b0;
                        busy_r        <= 1'b0;
                        rr_r          <= (grant_id_r == LAST_ID) ? {GW{1'b0}} : (grant_id_r + ONE_ID);
                        state_r       <= IDLE;
                    end else if (bus.tx_ready) begin
                        state_r <= LOAD;
                    end else begin
                        state_r <= WAIT_DONE;
                    end
                end
                default: begin
                    grant_valid_r <= 1'b0;
                    busy_r        <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.tx_data     = tx_data_r;
    assign bus.tx_start    = tx_start_r;
    assign bus.grant_id    = grant_id_r;
    assign bus.grant_valid = grant_valid_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter, checked every cycle against a
// transaction-level model of grant order, byte order and start-pulse timing.
module tb_uart_tx_arbiter;
    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int GW    = $clog2(N_REQ);

    logic clk = 1'b0;
    logic rstn;

    uart_tx_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();
    uart_tx_arbiter #(.N_REQ(N_REQ), .DW(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW:0]   drv_q [N_REQ][$];
    logic [DW:0]   mdl_q [N_REQ][$];
    int            gap_len [N_REQ];
    int            gap_cnt [N_REQ];
    int            rdy_cnt [N_REQ];
    int            tx_busy_len = 10;
    int            tx_busy_cnt = 0;
    int            ignore_starts = 0;
    int            owner_log[$];
    logic [DW-1:0] data_log[$];
    int            retry_cnt = 0;
    int            mdl_rr = 0;
    int            mdl_owner = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_scan(input logic [N_REQ-1:0] v, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic push_byte(input int r, input logic [DW-1:0] b, input logic last);
        drv_q[r].push_back({last, b});
        mdl_q[r].push_back({last, b});
    endtask

    task automatic push_rand_pkt(input int r, input int len);
        for (int i = 0; i < len; i++) begin
            push_byte(r, DW'($urandom), (i == len - 1) ? 1'b1 : 1'b0);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N_REQ; i++) s += drv_q[i].size() + mdl_q[i].size();
        return s;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int  n = 0;
        bit  done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (pending() == 0) && !bus.grant_valid && !bus.busy && bus.tx_ready;
        end
        check({name, "_drain"}, 32'(done), 32'd1);
    endtask

    task automatic check_log(input string name, input int exp_owner[$]);
        check({name, "_count"}, 32'(owner_log.size()), 32'(exp_owner.size()));
        for (int i = 0; i < exp_owner.size(); i++) begin
            if (i < owner_log.size()) check({name, "_owner"}, 32'(owner_log[i]), 32'(exp_owner[i]));
        end
    endtask

    // Requesters and transmitter: sample at negedge, drive just after posedge.
    initial begin : driver
        logic [N_REQ-1:0] acc;
        logic             st;
        logic [DW:0]      head;
        bus.req_valid = {N_REQ{1'b0}};
        bus.req_data  = {(N_REQ*DW){1'b0}};
        bus.req_last  = {N_REQ{1'b0}};
        bus.tx_ready  = 1'b1;
        forever begin
            @(negedge clk);
            acc = bus.req_ready;
            st  = bus.tx_start;
            @(posedge clk);
            #1;
            if (!rstn) begin
                for (int i = 0; i < N_REQ; i++) begin
                    drv_q[i].delete();
                    gap_cnt[i] = 0;
                end
                tx_busy_cnt = 0;
            end else begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (acc[i] && drv_q[i].size() > 0) begin
                        void'(drv_q[i].pop_front());
                        gap_cnt[i] = gap_len[i];
                    end
                end
                if (st) begin
                    if (ignore_starts > 0) ignore_starts--;
                    else tx_busy_cnt = tx_busy_len;
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (gap_cnt[i] > 0) begin
                    gap_cnt[i]--;
                    bus.req_valid[i] = 1'b0;
                end else if (drv_q[i].size() > 0) begin
                    head = drv_q[i][0];
                    bus.req_valid[i]          = 1'b1;
                    bus.req_data[i*DW +: DW]  = head[DW-1:0];
                    bus.req_last[i]           = head[DW];
                end else begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_last[i]  = 1'b0;
                end
            end
            if (tx_busy_cnt > 0) begin
                bus.tx_ready = 1'b0;
                tx_busy_cnt--;
            end else begin
                bus.tx_ready = 1'b1;
            end
        end
    end

    // Reference model and per-cycle comparison.
    initial begin : compare
        logic [N_REQ-1:0] pv;
        logic             pgv;
        logic             lat_due;
        logic             rdy_all;
        logic             last_sent;
        logic             exp_start;
        logic [DW-1:0]    pdata;
        logic [DW:0]      head;
        int               k_since;
        int               exp_owner;
        pv = '0; pgv = 1'b0; lat_due = 1'b0; rdy_all = 1'b0; last_sent = 1'b0;
        pdata = '0; k_since = 99;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                check("rst_req_ready", 32'(bus.req_ready), 32'd0);
                check("rst_tx_data", 32'(bus.tx_data), 32'd0);
                check("rst_tx_start", 32'(bus.tx_start), 32'd0);
                check("rst_grant_id", 32'(bus.grant_id), 32'd0);
                check("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
                check("rst_busy", 32'(bus.busy), 32'd0);
                for (int i = 0; i < N_REQ; i++) mdl_q[i].delete();
                mdl_rr = 0; mdl_owner = 0; pv = '0; pgv = 1'b0; lat_due = 1'b0;
                last_sent = 1'b0; k_since = 99; pdata = '0;
            end else begin
                if (lat_due) check("grant_to_start_latency", 32'(bus.tx_start), 32'd1);
                lat_due = 1'b0;
                if (!pgv) begin
                    check("grant_on_request", 32'(bus.grant_valid), 32'(|pv));
                    if (bus.grant_valid) begin
                        exp_owner = rr_scan(pv, mdl_rr);
                        if (exp_owner < 0) check("grant_without_request", 32'd1, 32'd0);
                        else mdl_owner = exp_owner;
                        last_sent = 1'b0;
                        lat_due = bus.req_valid[mdl_owner] && bus.tx_ready;
                    end
                end else if (!bus.grant_valid) begin
                    check("release_after_last", 32'(last_sent), 32'd1);
                    mdl_rr = (mdl_owner + 1) % N_REQ;
                end
                check("grant_id", 32'(bus.grant_id), 32'(mdl_owner));
                check("busy_vs_grant", 32'(bus.busy), 32'(bus.grant_valid));
                if (bus.req_ready != '0) begin
                    check("req_ready_onehot", 32'(bus.req_ready), 32'd1 << mdl_owner);
                    if (mdl_q[mdl_owner].size() == 0) begin
                        check("unexpected_byte", 32'd1, 32'd0);
                    end else begin
                        head = mdl_q[mdl_owner].pop_front();
                        check("tx_data", 32'(bus.tx_data), 32'(head[DW-1:0]));
                        last_sent = head[DW];
                    end
                    owner_log.push_back(mdl_owner);
                    data_log.push_back(bus.tx_data);
                    rdy_cnt[mdl_owner]++;
                    k_since = 0;
                    rdy_all = 1'b1;
                end else begin
                    check("tx_data_stable", 32'(bus.tx_data), 32'(pdata));
                    if (k_since < 99) k_since++;
                    if (k_since >= 1 && k_since <= 3) rdy_all = rdy_all & bus.tx_ready;
                end
                exp_start = (bus.req_ready != '0) || (k_since == 4 && rdy_all);
                check("tx_start", 32'(bus.tx_start), 32'(exp_start));
                if (exp_start && bus.req_ready == '0) retry_cnt++;
                pv = bus.req_valid;
                pgv = bus.grant_valid;
                pdata = bus.tx_data;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [DW-1:0] hola [4];
        int            rc0;
        int            seen;
        int            lows;
        hola[0] = 8'h48; hola[1] = 8'h6F; hola[2] = 8'h6C; hola[3] = 8'h61;
        for (int i = 0; i < N_REQ; i++) begin
            gap_len[i] = 0; gap_cnt[i] = 0; rdy_cnt[i] = 0;
        end
        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;

        // "Hola" from requester 0
        tx_busy_len = 10;
        owner_log.delete(); data_log.delete();
        for (int i = 0; i < 4; i++) push_byte(0, hola[i], (i == 3) ? 1'b1 : 1'b0);
        wait_idle("hola", 2000);
        check("hola_count", 32'(data_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < data_log.size()) check("hola_byte", 32'(data_log[i]), 32'(hola[i]));
        end
        check("hola_ready_pulses", 32'(rdy_cnt[0]), 32'd4);
        check("hola_released", 32'(bus.grant_valid), 32'd0);

        // Requesters 1 and 3 simultaneously, 2-byte packets
        owner_log.delete();
        push_byte(1, 8'hA0, 1'b0); push_byte(1, 8'hA1, 1'b1);
        push_byte(3, 8'hB0, 1'b0); push_byte(3, 8'hB1, 1'b1);
        wait_idle("pair", 2000);
        check_log("pair", '{1, 1, 3, 3});
        check("pair_rr_wrap", 32'(mdl_rr), 32'd0);

        // Fairness: all four with two single-byte packets queued
        owner_log.delete();
        tx_busy_len = 3;
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < N_REQ; r++) push_byte(r, 8'(16*r + p), 1'b1);
        wait_idle("fair", 2000);
        check_log("fair", '{0, 1, 2, 3, 0, 1, 2, 3});

        // Owner stalls mid-packet while requester 2 waits
        owner_log.delete();
        gap_len[0] = 20;
        rc0 = rdy_cnt[0];
        push_rand_pkt(0, 3);
        push_byte(2, 8'h5A, 1'b1);
        seen = 0;
        while (rdy_cnt[0] == rc0 && seen < 200) begin
            @(negedge clk);
            seen++;
        end
        repeat (12) @(negedge clk);
        check("stall_owner_invalid", 32'(bus.req_valid[0]), 32'd0);
        check("stall_other_valid", 32'(bus.req_valid[2]), 32'd1);
        check("stall_grant_id", 32'(bus.grant_id), 32'd0);
        check("stall_grant_valid", 32'(bus.grant_valid), 32'd1);
        check("stall_busy", 32'(bus.busy), 32'd1);
        wait_idle("stall", 3000);
        check_log("stall", '{0, 0, 0, 2});
        gap_len[0] = 0;

        // Transmitter misses the first start pulse
        owner_log.delete();
        rc0 = retry_cnt;
        ignore_starts = 1;
        push_byte(1, 8'hC3, 1'b1);
        wait_idle("retry", 2000);
        check("retry_pulses", 32'(retry_cnt - rc0), 32'd1);
        check_log("retry", '{1});

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < N_REQ; r++) gap_len[r] = $urandom_range(0, 3);
            tx_busy_len = $urandom_range(1, 12);
            if (!bus.busy && ignore_starts == 0 && $urandom_range(0, 7) == 0) ignore_starts = 1;
            push_rand_pkt($urandom_range(0, N_REQ - 1), $urandom_range(1, 4));
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_idle("random", 20000);
        for (int r = 0; r < N_REQ; r++) gap_len[r] = 0;

        // Reset asserted while waiting for the transmitter to finish
        tx_busy_len = 10;
        push_byte(1, 8'h11, 1'b0); push_byte(1, 8'h22, 1'b1);
        seen = 0; lows = 0;
        for (int n = 0; n < 300 && lows < 2; n++) begin
            @(negedge clk);
            if (bus.tx_start) seen = 1;
            if (seen != 0 && !bus.tx_ready) lows++;
        end
        check("mid_reset_reached_wait", 32'(lows), 32'd2);
        check("mid_reset_pre_grant", 32'(bus.grant_valid), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_grant_valid", 32'(bus.grant_valid), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("async_rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("async_rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("async_rst_req_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        owner_log.delete();
        push_byte(3, 8'h33, 1'b1);
        push_byte(0, 8'h44, 1'b1);
        wait_idle("post_reset", 2000);
        check_log("post_reset", '{0, 3});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
